// File: rtl/demux4_1_buf.sv
// Registered 1-to-4 demultiplexer: each accepted word is steered by in_sel into a
// one-entry holding buffer per channel, with independent valid/ready on every port.
module demux4_1_buf #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic [7:0]         xfer_count
);

   logic [WIDTH-1:0] r_buf [4];
   logic [3:0]       r_valid;
   logic [7:0]       r_count;

   logic             w_accept;
   logic [3:0]       w_load;
   logic [3:0]       w_pop;

   // A channel can take a word if it is empty or is being drained this same edge.
   assign in_ready = !r_valid[in_sel] || out_ready[in_sel];
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_load = 4'b0000;
      if (w_accept) begin
         w_load[in_sel] = 1'b1;
      end
   end

   assign w_pop = r_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 4'b0000;
         r_count <= 8'd0;
         for (int i = 0; i < 4; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // Load takes priority over pop so a drained channel refills without a bubble.
            if (w_load[i]) begin
               r_buf[i]   <= in_data;
               r_valid[i] <= 1'b1;
            end else if (w_pop[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
         if (w_accept) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         out_data[i*WIDTH +: WIDTH] = r_buf[i];
      end
   end

   assign out_valid  = r_valid;
   assign xfer_count = r_count;

endmodule

// File: tb/tb_demux4_1_buf.sv
// Directed bench for demux4_1_buf: steering, backpressure, channel independence,
// pop+load on one channel, reset mid-traffic and the 8-bit transfer counter wrap.
module tb_demux4_1_buf;

   localparam int W = 64;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [1:0]   in_sel;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [4*W-1:0] out_data;
   logic [7:0]   xfer_count;

   int n_cmp = 0;
   int n_err = 0;

   demux4_1_buf #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ch(input int i);
      return out_data[i*W +: W];
   endfunction

   // advance one edge, then settle well clear of it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] sel, input logic [W-1:0] d);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
   endtask

   initial begin
      logic [1:0]   lsel;
      logic [W-1:0] ldat;
      reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_valid", out_valid, 4'b0000);
      chk("rst_data", out_data[W-1:0] | out_data[2*W-1:W] | out_data[3*W-1:2*W] | out_data[4*W-1:3*W], '0);
      chk("rst_count", xfer_count, 8'd0);
      chk("rst_ready", in_ready, 1'b1);

      // basic steering, all consumers ready
      out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         send(k[1:0], 64'hA0 + k);
         step();
         chk($sformatf("steer_valid%0d", k), out_valid, 4'b0001 << k);
         chk($sformatf("steer_data%0d", k), ch(k), 64'hA0 + k);
      end
      in_valid = 1'b0;
      step();
      chk("steer_drained", out_valid, 4'b0000);
      chk("steer_count", xfer_count, 8'd4);

      // backpressure on channel 1
      out_ready = 4'b1101;
      send(2'd1, 64'h11);
      step();
      chk("bp_valid", out_valid, 4'b0010);
      chk("bp_data", ch(1), 64'h11);
      chk("bp_count", xfer_count, 8'd5);
      send(2'd1, 64'h22);
      #1;
      chk("bp_ready_low", in_ready, 1'b0);
      step();
      chk("bp_hold_data", ch(1), 64'h11);
      chk("bp_hold_valid", out_valid, 4'b0010);
      chk("bp_hold_count", xfer_count, 8'd5);
      out_ready = 4'b1111;
      #1;
      chk("bp_ready_high", in_ready, 1'b1);
      step();
      chk("bp_new_data", ch(1), 64'h22);
      chk("bp_new_valid", out_valid, 4'b0010);
      chk("bp_new_count", xfer_count, 8'd6);
      in_valid = 1'b0;
      step();
      chk("bp_drained", out_valid, 4'b0000);

      // independence: channel 3 stalled and full
      out_ready = 4'b0111;
      send(2'd3, 64'h44);
      step();
      chk("ind_full3", out_valid, 4'b1000);
      send(2'd0, 64'h33);
      #1;
      chk("ind_ready0", in_ready, 1'b1);
      step();
      chk("ind_valid", out_valid, 4'b1001);
      chk("ind_data0", ch(0), 64'h33);
      chk("ind_data3", ch(3), 64'h44);
      chk("ind_count", xfer_count, 8'd8);
      in_valid = 1'b0;
      step();
      chk("ind_pop0", out_valid, 4'b1000);
      chk("ind_keep3", ch(3), 64'h44);
      out_ready = 4'b1111;
      step();
      chk("ind_drained", out_valid, 4'b0000);

      // simultaneous pop and load on channel 2
      out_ready = 4'b0000;
      send(2'd2, 64'h5);
      step();
      chk("pl_first", ch(2), 64'h5);
      out_ready = 4'b0100;
      send(2'd2, 64'h6);
      #1;
      chk("pl_ready", in_ready, 1'b1);
      step();
      chk("pl_valid", out_valid, 4'b0100);
      chk("pl_data", ch(2), 64'h6);
      chk("pl_count", xfer_count, 8'd10);
      in_valid = 1'b0;
      step();
      chk("pl_drained", out_valid, 4'b0000);

      // reset mid-traffic with channel 2 full and an offered word on the reset edge
      out_ready = 4'b0000;
      send(2'd2, 64'h77);
      step();
      chk("mr_full2", out_valid, 4'b0100);
      chk("mr_count", xfer_count, 8'd11);
      send(2'd0, 64'h99);
      reset = 1'b1;
      step(); step();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("mr_valid", out_valid, 4'b0000);
      chk("mr_data", out_data[W-1:0] | out_data[2*W-1:W] | out_data[3*W-1:2*W] | out_data[4*W-1:3*W], '0);
      chk("mr_count0", xfer_count, 8'd0);
      chk("mr_ready", in_ready, 1'b1);

      // 256 accepts wrap the counter back to zero
      out_ready = 4'b1111;
      lsel = 2'd0; ldat = '0;
      for (int k = 0; k < 256; k++) begin
         lsel = 2'($urandom_range(0, 3));
         ldat = {$urandom, $urandom};
         send(lsel, ldat);
         step();
      end
      chk("wrap_count", xfer_count, 8'd0);
      chk("wrap_last", ch(int'(lsel)), ldat);
      send(2'd1, 64'hBEEF);
      step();
      chk("wrap_257", xfer_count, 8'd1);
      chk("wrap_257_data", ch(1), 64'hBEEF);
      in_valid = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux4_1_buf.md
# demux4_1_buf

Registered 1-to-4 demultiplexer with one-entry output buffers and valid/ready handshakes on every port. It steers each accepted input word to one of four output channels selected by a 2-bit select. It is the distributing counterpart to the 4:1 select mux. It sits between a single producer (e.g. a writeback or result bus) and four independent consumers (e.g. per-bank or per-unit write ports).

## Interface
- WIDTH, 64, data width of input and of each output channel

- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word on in_data/in_sel
- in_ready  output  1  block can accept the word this cycle
- in_data  input  WIDTH  word to steer
- in_sel  input  2  destination channel 0..3
- out_valid  output  4  bit i: channel i holds a word
- out_ready  input  4  bit i: consumer i takes the word this cycle
- out_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- xfer_count  output  8  number of accepted input words, wraps modulo 256

## Operation
- The clock is clk. reset is synchronous and active-high: it is sampled only on the rising edge of clk.
- Each channel i has one holding register buf[i] and one flag out_valid[i].
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. It is combinational from in_sel, out_valid and out_ready. It does not depend on in_valid.
- Accept: the input is accepted when in_valid && in_ready at a rising edge. On accept:
  - buf[in_sel] <= in_data;
  - out_valid[in_sel] <= 1;
  - xfer_count <= xfer_count + 1 (8-bit, wraps 255 -> 0).
- Pop: channel i pops when out_valid[i] && out_ready[i] at a rising edge.
  - If channel i is not also loaded on that edge, out_valid[i] <= 0.
  - buf[i] is not cleared.
- Simultaneous pop and load on the same channel: the load wins. out_valid[i] stays 1, buf[i] takes the new word. No bubble.
- Channels are independent. A stalled channel never blocks accepts to other channels.
- When out_valid[i] is 0, out_ready[i] is ignored.
- While out_valid[i] && !out_ready[i]: out_data channel i and out_valid[i] hold stable.
- in_data and in_sel are don't-care when in_valid is 0. in_sel is sampled only at accept.
- No reordering within a channel: one word is buffered per channel at most.

## Timing
- Reset values: out_valid = 4'b0000, out_data = all zeros, xfer_count = 0. in_ready therefore evaluates to 1 after reset.
- Reset mid-operation clears all buffers and the count on that edge. Buffered words are discarded. Any accept on the reset edge is ignored.
- Latency: a word accepted at edge N appears on out_data channel in_sel with out_valid set after edge N.
- Throughput: one word per cycle into any channel whose consumer keeps out_ready high. This includes back-to-back words to the same channel.
- Full channel (out_valid=1, out_ready=0): in_ready is 0 for words targeting it. Nothing changes on that edge.
- No combinational path from in_valid or in_data to any output. The only combinational path is from in_sel/out_ready to in_ready.

## Test plan
- Reset: assert reset 2 cycles mid-traffic with channel 2 full -> out_valid=0000, out_data=0, xfer_count=0, in_ready=1.
- Basic steering: out_ready=1111, send 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles -> each channel i shows 0xA0+i one cycle after accept, with a single out_valid[i] pulse. xfer_count=4.
- Backpressure: out_ready[1]=0, send 0x11 then 0x22 to channel 1 -> 0x11 is held. in_ready=0 while in_sel=1. Raise out_ready[1] -> 0x11 pops, 0x22 is accepted on the same edge and then visible.
- Independence: channel 3 stalled and full, then send 0x33 to channel 0 -> accepted immediately. Channel 3 word unchanged.
- Simultaneous pop+load: channel 2 full with 0x5, out_ready[2]=1, send 0x6 to channel 2 -> out_valid[2] stays 1, data becomes 0x6 with no gap cycle.
- Wrap: 256 accepts with random sel and out_ready=1111 -> xfer_count returns to 0. 257th accept -> xfer_count=1.
